multi_mode_timer: RTL

Parametrised tick-based timer: a programmable prescaler turns the fast system clock into a slow count tick, and a CNT_W-bit counter advances on each tick in one of four modes (free-run up, one-shot down, auto-reload down, up-to-limit). It succeeds the fixed 16-bit up-counter timer by adding configurable width and tick rate, start/pause/clear control, a terminal-count pulse and busy status. It sits next to the display/FSM logic that consumes t_out/t_valid.

---
 rtl/multi_mode_timer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/multi_mode_timer.sv
// Tick-based timer: a prescaler divides clk into count ticks, and a CNT_W-bit
// counter advances on each tick in free-run, one-shot, auto-reload or up-to-limit mode.
module multi_mode_timer #(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_en,
  input  logic [1:0]       t_mode,
  input  logic [CNT_W-1:0] t_load,
  input  logic             t_pause,
  input  logic             t_clear,
  output logic [CNT_W-1:0] t_out,
  output logic             t_valid,
  output logic             t_done,
  output logic             t_busy
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRESC_ZERO = '0;
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  localparam logic [1:0] MODE_FREE    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_RELOAD  = 2'b10;
  localparam logic [1:0] MODE_LIMIT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [PW-1:0]    presc_r;
  logic [1:0]       mode_r;
  logic [CNT_W-1:0] load_r;
  logic             en_prev_r;

  logic             start_s;
  logic             can_start_s;
  logic             tick_s;
  logic [CNT_W-1:0] inc_s;
  logic [CNT_W-1:0] dec_s;
  logic [CNT_W-1:0] next_out_s;
  logic             tick_done_s;
  logic             tick_stop_s;
  logic             start_degen_s;

  assign start_s       = t_en & ~en_prev_r;
  assign can_start_s   = (state_r == IDLE) || (state_r == DONE);
  assign tick_s        = (state_r == RUN) && !t_pause && (presc_r == PRESC_LAST);
  assign inc_s         = t_out + CNT_ONE;
  assign dec_s         = t_out - CNT_ONE;
  assign start_degen_s = (t_mode != MODE_FREE) && (t_load == CNT_ZERO);

  // Counter value and terminal-count flags that the next tick would produce
  always_comb begin
    next_out_s  = t_out;
    tick_done_s = 1'b0;
    tick_stop_s = 1'b0;
    case (mode_r)
      MODE_FREE: begin
        next_out_s  = inc_s;
        tick_done_s = (t_out == CNT_MAX);
      end
      MODE_ONESHOT: begin
        next_out_s  = dec_s;
        tick_done_s = (t_out == CNT_ONE);
        tick_stop_s = (t_out == CNT_ONE);
      end
      MODE_RELOAD: begin
        next_out_s  = (t_out == CNT_ZERO) ? load_r : dec_s;
        tick_done_s = (t_out == CNT_ONE);
      end
      MODE_LIMIT: begin
        next_out_s  = inc_s;
        tick_done_s = (inc_s == load_r);
        tick_stop_s = (inc_s == load_r);
      end
      default: begin
        next_out_s  = t_out;
        tick_done_s = 1'b0;
        tick_stop_s = 1'b0;
      end
    endcase
  end

  // Control FSM, prescaler and registered outputs; clear outranks start outranks pause/tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      presc_r   <= PRESC_ZERO;
      mode_r    <= 2'b00;
      load_r    <= CNT_ZERO;
      en_prev_r <= 1'b1;
      t_out     <= CNT_ZERO;
      t_valid   <= 1'b0;
      t_done    <= 1'b0;
      t_busy    <= 1'b0;
    end else begin
      en_prev_r <= t_en;
      t_valid   <= 1'b0;
      t_done    <= 1'b0;
      if (t_clear) begin
        state_r <= IDLE;
        presc_r <= PRESC_ZERO;
        t_out   <= CNT_ZERO;
        t_busy  <= 1'b0;
      end else if (start_s && can_start_s) begin
        mode_r  <= t_mode;
        load_r  <= t_load;
        presc_r <= PRESC_ZERO;
        t_valid <= 1'b1;
        if (start_degen_s) begin
          // a zero load/limit has nothing to count: finish on the start edge
          t_out   <= CNT_ZERO;
          t_done  <= 1'b1;
          state_r <= DONE;
          t_busy  <= 1'b0;
        end else begin
          t_out   <= ((t_mode == MODE_ONESHOT) || (t_mode == MODE_RELOAD)) ? t_load : CNT_ZERO;
          state_r <= RUN;
          t_busy  <= 1'b1;
        end
      end else begin
        case (state_r)
          RUN: begin
            if (t_pause) begin
              state_r <= PAUSE;
            end else if (tick_s) begin
              presc_r <= PRESC_ZERO;
              t_out   <= next_out_s;
              t_valid <= 1'b1;
              t_done  <= tick_done_s;
              if (tick_stop_s) begin
                state_r <= DONE;
                t_busy  <= 1'b0;
              end else begin
                state_r <= RUN;
              end
            end else begin
              presc_r <= presc_r + PRESC_ONE;
            end
          end
          PAUSE: begin
            if (!t_pause) begin
              state_r <= RUN;
            end else begin
              state_r <= PAUSE;
            end
          end
          IDLE:    state_r <= IDLE;
          DONE:    state_r <= DONE;
          default: begin
            state_r <= IDLE;
            t_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
